// File: rtl/riscv_pkg.sv
// Shared RV32 front-end types: word width, the canonical NOP and the
// {instr, pc} record carried from fetch into decode.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {instr, pc} entries; flush wins over push/pop.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Storage needs no reset: nothing reads it while the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && !flush) assert (!(pop && empty)) else $error("fetch_queue: pop while empty");
  end
endmodule

// File: rtl/fetch_decode_pipe.sv
// IF/ID stage: owns the fetch PC, issues one-cycle-latency imem reads and
// buffers returned words so decode stalls never lose an in-flight fetch.
module fetch_decode_pipe
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] PC_out,
  output logic        valid_out
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_f, inflight_pc;
  logic            inflight_v, inflight_epoch, epoch;
  logic            deq, push, pop;
  logic [CW:0]     occ;
  fetch_entry_t    head, din;
  logic [CW-1:0]   count;
  logic            q_full, q_empty;

  assign valid_out = ~q_empty;
  assign deq       = valid_out & ~stall;

  // Space check counts the outstanding response so a stall can never overflow.
  assign occ      = {1'b0, count} + (CW+1)'(inflight_v) - (CW+1)'(deq);
  assign imem_req = rstn & ~redirect & (occ < (CW+1)'(DEPTH));
  assign imem_addr = pc_f;

  assign push = inflight_v & (inflight_epoch == epoch) & ~redirect;
  assign pop  = deq & ~redirect;
  assign din  = '{instr: imem_rdata, pc: inflight_pc};

  assign instruction_out = valid_out ? head.instr : NOP_INSTR;
  assign PC_out          = valid_out ? head.pc    : '0;

  fetch_queue #(.DEPTH(DEPTH)) u_q (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (din),
    .head  (head),
    .count (count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_f           <= {RESET_PC[31:2], 2'b00};
      inflight_v     <= 1'b0;
      inflight_pc    <= '0;
      inflight_epoch <= 1'b0;
      epoch          <= 1'b0;
    end else if (redirect) begin
      pc_f       <= {redirect_pc[31:2], 2'b00};
      inflight_v <= 1'b0;
      epoch      <= ~epoch;
    end else begin
      inflight_v <= imem_req;
      if (imem_req) begin
        inflight_pc    <= pc_f;
        inflight_epoch <= epoch;
        pc_f           <= pc_f + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) assert (!(push && q_full && !pop)) else $error("fetch_decode_pipe: enqueue into full queue");
  end
endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Directed bench for fetch_decode_pipe: queue-based reference model compared
// every cycle, plus hand-computed checkpoints along the test scenarios.
module tb_fetch_decode_pipe;
  import riscv_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0, rstn = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic [31:0] imem_addr, instruction_out, PC_out;
  logic        imem_req, valid_out;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  fetch_decode_pipe #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .instruction_out (instruction_out),
    .PC_out          (PC_out),
    .valid_out       (valid_out)
  );

  // Instruction memory: word at A reads as A+0x100, garbage when not requested.
  always @(posedge clk) imem_rdata <= imem_req ? imem_addr + 32'h100 : 32'hDEAD_BEEF;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: a plain queue of delivered words plus the one outstanding fetch.
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc = RPC;
  bit          m_inf = 1'b0;
  logic [31:0] m_inf_pc = '0;

  always @(negedge clk) begin
    bit v, d, r;
    if (!rstn) begin
      chk("m_rst_valid", valid_out, 0);
      chk("m_rst_instr", instruction_out, NOP_INSTR);
      chk("m_rst_pc", PC_out, 0);
      chk("m_rst_req", imem_req, 0);
      mq.delete();
      m_pc  = RPC;
      m_inf = 1'b0;
    end else begin
      v = (mq.size() != 0);
      d = v && !stall;
      r = !redirect && ((mq.size() + int'(m_inf) - int'(d)) < DEPTH);
      chk("m_valid", valid_out, v);
      if (v) begin
        chk("m_pc_out", PC_out, mq[0].pc);
        chk("m_instr", instruction_out, mq[0].ins);
      end else begin
        chk("m_pc_out", PC_out, 0);
        chk("m_instr", instruction_out, NOP_INSTR);
      end
      chk("m_req", imem_req, r);
      if (r) chk("m_addr", imem_addr, m_pc);
      if (redirect) begin
        mq.delete();
        m_pc  = {redirect_pc[31:2], 2'b00};
        m_inf = 1'b0;
      end else begin
        if (d) void'(mq.pop_front());
        if (m_inf) mq.push_back('{pc: m_inf_pc, ins: m_inf_pc + 32'h100});
        m_inf = r;
        if (r) begin
          m_inf_pc = m_pc;
          m_pc     = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc [4];
    logic [15:0] pat;
    exp_pc = '{32'h10, 32'h14, 32'h18, 32'h1C};

    repeat (2) cyc();
    @(negedge clk);
    chk("rst_valid", valid_out, 0);
    chk("rst_instr", instruction_out, 32'h13);
    chk("rst_req", imem_req, 0);

    cyc(); rstn = 1'b1;                                   // c0
    @(negedge clk); chk("c0_req", imem_req, 1); chk("c0_addr", imem_addr, 32'h0);
    cyc(); @(negedge clk); chk("c1_addr", imem_addr, 32'h4); chk("c1_valid", valid_out, 0);
    cyc(); @(negedge clk);
    chk("c2_valid", valid_out, 1); chk("c2_pc", PC_out, 32'h0); chk("c2_instr", instruction_out, 32'h100);

    // Stall with head at 0x10: two more fetches fill the queue, then fetch stops.
    repeat (4) cyc(); stall = 1'b1;                       // c6
    @(negedge clk); chk("st_pc0", PC_out, 32'h10); chk("st_req0", imem_req, 1); chk("st_addr0", imem_addr, 32'h18);
    cyc(); @(negedge clk); chk("st_pc1", PC_out, 32'h10); chk("st_addr1", imem_addr, 32'h1C);
    cyc(); @(negedge clk); chk("st_req2", imem_req, 0);
    cyc(); @(negedge clk); chk("st_req3", imem_req, 0);
    cyc(); @(negedge clk); chk("st_pc4", PC_out, 32'h10);
    cyc(); stall = 1'b0;                                  // c11
    for (int i = 0; i < 4; i++) begin
      if (i != 0) cyc();
      @(negedge clk);
      chk("st_rel_valid", valid_out, 1);
      chk("st_rel_pc", PC_out, exp_pc[i]);
    end

    // One-cycle reset pulse mid-stream.
    cyc(); rstn = 1'b0;
    @(negedge clk);
    chk("rp_valid", valid_out, 0); chk("rp_instr", instruction_out, 32'h13); chk("rp_pc", PC_out, 0);
    cyc(); rstn = 1'b1;                                   // c0
    @(negedge clk); chk("rp_addr", imem_addr, RPC); chk("rp_valid0", valid_out, 0);
    cyc(); @(negedge clk); chk("rp_valid1", valid_out, 0); chk("rp_instr1", instruction_out, 32'h13);
    cyc(); @(negedge clk); chk("rp_pc2", PC_out, RPC); chk("rp_valid2", valid_out, 1);

    // Redirect while the fetch of 0x20 is outstanding.
    repeat (7) cyc(); redirect = 1'b1; redirect_pc = 32'h200;   // c9
    @(negedge clk); chk("rd_req", imem_req, 0); chk("rd_head", PC_out, 32'h1C);
    cyc(); redirect = 1'b0;
    @(negedge clk); chk("rd_v0", valid_out, 0); chk("rd_addr0", imem_addr, 32'h200);
    cyc(); @(negedge clk); chk("rd_v1", valid_out, 0); chk("rd_addr1", imem_addr, 32'h204);
    cyc(); @(negedge clk); chk("rd_pc0", PC_out, 32'h200); chk("rd_instr0", instruction_out, 32'h300);
    cyc(); stall = 1'b1;                                  // c13
    @(negedge clk); chk("rd_pc1", PC_out, 32'h204);

    // Redirect into a stalled, full queue.
    cyc(); cyc(); @(negedge clk); chk("fq_req", imem_req, 0);
    cyc(); redirect = 1'b1; redirect_pc = 32'h500;        // c16
    @(negedge clk); chk("fq_rreq", imem_req, 0);
    cyc(); redirect = 1'b0;
    @(negedge clk); chk("fq_valid", valid_out, 0); chk("fq_addr", imem_addr, 32'h500);
    cyc(); stall = 1'b0;
    cyc(); @(negedge clk); chk("fq_pc", PC_out, 32'h500); chk("fq_instr", instruction_out, 32'h600);

    // Back-to-back redirects: only the second target is ever seen.
    cyc(); redirect = 1'b1; redirect_pc = 32'h300;
    cyc(); redirect_pc = 32'h400;
    @(negedge clk); chk("bb_req", imem_req, 0);
    cyc(); redirect = 1'b0;
    @(negedge clk); chk("bb_addr", imem_addr, 32'h400); chk("bb_v0", valid_out, 0);
    cyc(); @(negedge clk); chk("bb_v1", valid_out, 0);
    cyc(); @(negedge clk); chk("bb_pc", PC_out, 32'h400); chk("bb_instr", instruction_out, 32'h500);

    // Irregular stall pattern, checked by the model alone.
    pat = 16'b0110_0011_1000_1101;
    for (int i = 0; i < 16; i++) begin
      cyc(); stall = pat[i];
    end
    cyc(); stall = 1'b0;
    repeat (10) cyc();

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
